// File: rtl/mod12_timer_pkg.sv
// rtl/mod12_timer_pkg.sv - shared states, modulus default and clamp helper for the mod-12 countdown timer
package mod12_timer_pkg;

  localparam int MOD_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Out-of-range values fold to the largest legal count, matching the up counter.
  function automatic logic [31:0] clamp_mod(input logic [31:0] data, input int unsigned mod);
    return (data >= mod) ? (mod - 32'd1) : data;
  endfunction

endpackage

// File: rtl/mod12_prescaler.sv
// rtl/mod12_prescaler.sv - free-running 0..PRESCALE-1 divider producing one tick per wrap while enabled
module mod12_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt;

  // Holding while disabled keeps a paused tick pending for the first cycle after resume.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= (pcnt == LAST) ? '0 : pcnt + PW'(1);
    end
  end

  assign tick = en && (pcnt == LAST);

endmodule

// File: rtl/mod12_countdown_timer.sv
// rtl/mod12_countdown_timer.sv - loadable mod-12 countdown timer with start/pause, prescaler and auto-reload
module mod12_countdown_timer
  import mod12_timer_pkg::*;
#(
  parameter int MOD      = MOD_DEFAULT,
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             pre_en, pre_clr, tick;

  assign pre_en  = (state_q == RUN) && !pause && !load;
  assign pre_clr = load || (start && ((state_q == IDLE) || (state_q == DONE)));

  mod12_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = WIDTH'(clamp_mod(32'(data), MOD));
      reload_d = WIDTH'(clamp_mod(32'(data), MOD));
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (count_q != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (tick) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (auto_reload) begin
              count_d = reload_q;
              done_d  = 1'b1;
            end else begin
              count_d = '0;
              done_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
        PAUSED: begin
          if (!pause && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start) begin
            count_d = reload_q;
            if (reload_q != '0) begin
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign count  = count_q;
  assign busy   = (state_q == RUN) || (state_q == PAUSED);
  assign paused = (state_q == PAUSED);
  assign done   = done_q;

endmodule

// File: tb/tb_mod12_countdown_timer.sv
// tb/tb_mod12_countdown_timer.sv - directed self-checking bench for mod12_countdown_timer
module tb_mod12_countdown_timer;

  logic       clk = 1'b0;
  logic       reset, load, start, pause, auto_reload;
  logic [3:0] data;
  logic [3:0] count1, count4;
  logic       busy1, paused1, done1, busy4, paused4, done4;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  always #5 clk = ~clk;

  mod12_countdown_timer #(.MOD(12), .WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .data(data), .start(start), .pause(pause),
    .auto_reload(auto_reload), .count(count1), .busy(busy1), .paused(paused1), .done(done1)
  );

  mod12_countdown_timer #(.MOD(12), .WIDTH(4), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .data(data), .start(start), .pause(pause),
    .auto_reload(auto_reload), .count(count4), .busy(busy4), .paused(paused4), .done(done4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] v);
    data = v; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 0; start = 0; pause = 0; auto_reload = 0; data = 4'd0;
    cyc(); cyc();
    reset = 1'b0;
    total_cnt++; if (count1 !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count1); else pass_cnt++;
    total_cnt++; if ({busy1, paused1, done1} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {busy1, paused1, done1}); else pass_cnt++;
    total_cnt++; if ({count4, busy4, paused4, done4} !== 7'd0) $display("FAIL reset_dut4 got=%b exp=0", {count4, busy4, paused4, done4}); else pass_cnt++;
  endtask

  task automatic test_oneshot();
    do_load(4'd7);
    total_cnt++; if (count1 !== 4'd7 || busy1 !== 1'b0) $display("FAIL oneshot_load count=%0d busy=%b exp=7,0", count1, busy1); else pass_cnt++;
    do_start();
    total_cnt++; if (count1 !== 4'd7 || busy1 !== 1'b1) $display("FAIL oneshot_start count=%0d busy=%b exp=7,1", count1, busy1); else pass_cnt++;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      total_cnt++; if (count1 !== 4'(7 - k)) $display("FAIL oneshot_count k=%0d got=%0d exp=%0d", k, count1, 7 - k); else pass_cnt++;
      total_cnt++; if (done1 !== (k == 7)) $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, done1, (k == 7)); else pass_cnt++;
    end
    cyc();
    total_cnt++; if ({done1, busy1, count1} !== 6'd0) $display("FAIL oneshot_after done=%b busy=%b count=%0d exp=0,0,0", done1, busy1, count1); else pass_cnt++;
  endtask

  task automatic test_clamp_restart();
    do_load(4'd15);
    total_cnt++; if (count1 !== 4'd11) $display("FAIL clamp_count got=%0d exp=11", count1); else pass_cnt++;
    do_start();
    for (int k = 0; k < 11; k++) cyc();
    total_cnt++; if (done1 !== 1'b1 || count1 !== 4'd0) $display("FAIL clamp_expiry done=%b count=%0d exp=1,0", done1, count1); else pass_cnt++;
    cyc();
    do_start();
    total_cnt++; if (count1 !== 4'd11 || busy1 !== 1'b1 || done1 !== 1'b0) $display("FAIL restart count=%0d busy=%b done=%b exp=11,1,0", count1, busy1, done1); else pass_cnt++;
    cyc();
    total_cnt++; if (count1 !== 4'd10) $display("FAIL restart_dec got=%0d exp=10", count1); else pass_cnt++;
    do_load(4'd0);
  endtask

  task automatic test_auto_reload();
    auto_reload = 1'b1;
    do_load(4'd3);
    do_start();
    for (int j = 1; j <= 36; j++) begin
      cyc();
      total_cnt++; if (count4 !== 4'(3 - ((j / 4) % 3))) $display("FAIL auto_count j=%0d got=%0d exp=%0d", j, count4, 3 - ((j / 4) % 3)); else pass_cnt++;
      total_cnt++; if (done4 !== (j % 12 == 0)) $display("FAIL auto_done j=%0d got=%b exp=%b", j, done4, (j % 12 == 0)); else pass_cnt++;
      total_cnt++; if (busy4 !== 1'b1) $display("FAIL auto_busy j=%0d got=%b exp=1", j, busy4); else pass_cnt++;
    end
    auto_reload = 1'b0;
    do_load(4'd0);
  endtask

  task automatic test_pause();
    do_load(4'd5);
    do_start();
    cyc(); cyc();
    total_cnt++; if (count1 !== 4'd3) $display("FAIL pause_pre got=%0d exp=3", count1); else pass_cnt++;
    pause = 1'b1;
    cyc(); cyc();
    total_cnt++; if (count1 !== 4'd3 || paused1 !== 1'b1 || busy1 !== 1'b1) $display("FAIL pause_hold count=%0d paused=%b busy=%b exp=3,1,1", count1, paused1, busy1); else pass_cnt++;
    pause = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    total_cnt++; if (count1 !== 4'd3 || paused1 !== 1'b0) $display("FAIL pause_resume count=%0d paused=%b exp=3,0", count1, paused1); else pass_cnt++;
    cyc(); cyc();
    total_cnt++; if (count1 !== 4'd1 || done1 !== 1'b0) $display("FAIL pause_late count=%0d done=%b exp=1,0", count1, done1); else pass_cnt++;
    cyc();
    total_cnt++; if (count1 !== 4'd0 || done1 !== 1'b1) $display("FAIL pause_expiry count=%0d done=%b exp=0,1", count1, done1); else pass_cnt++;
    do_load(4'd5);
    do_start();
    pause = 1'b1; start = 1'b1;
    cyc();
    total_cnt++; if (paused1 !== 1'b1 || count1 !== 4'd5) $display("FAIL pause_wins paused=%b count=%0d exp=1,5", paused1, count1); else pass_cnt++;
    cyc();
    total_cnt++; if (paused1 !== 1'b1) $display("FAIL pause_stays got=%b exp=1", paused1); else pass_cnt++;
    pause = 1'b0;
    cyc();
    start = 1'b0;
    total_cnt++; if (paused1 !== 1'b0 || busy1 !== 1'b1) $display("FAIL pause_restart paused=%b busy=%b exp=0,1", paused1, busy1); else pass_cnt++;
    do_load(4'd0);
  endtask

  task automatic test_pause_on_tick();
    do_load(4'd1);
    do_start();
    cyc(); cyc(); cyc();
    pause = 1'b1;
    cyc();
    pause = 1'b0;
    total_cnt++; if (done4 !== 1'b0 || count4 !== 4'd1 || paused4 !== 1'b1) $display("FAIL tick_lost done=%b count=%0d paused=%b exp=0,1,1", done4, count4, paused4); else pass_cnt++;
    do_start();
    total_cnt++; if (done4 !== 1'b0 || busy4 !== 1'b1) $display("FAIL tick_resume done=%b busy=%b exp=0,1", done4, busy4); else pass_cnt++;
    cyc();
    total_cnt++; if (done4 !== 1'b1 || count4 !== 4'd0) $display("FAIL tick_first done=%b count=%0d exp=1,0", done4, count4); else pass_cnt++;
    do_load(4'd0);
  endtask

  task automatic test_zero_and_abort();
    do_load(4'd0);
    do_start();
    total_cnt++; if (done1 !== 1'b1 || count1 !== 4'd0 || busy1 !== 1'b0) $display("FAIL zero_start done=%b count=%0d busy=%b exp=1,0,0", done1, count1, busy1); else pass_cnt++;
    cyc();
    total_cnt++; if (done1 !== 1'b0) $display("FAIL zero_pulse got=%b exp=0", done1); else pass_cnt++;
    do_load(4'd4);
    do_start();
    cyc(); cyc();
    total_cnt++; if (count1 !== 4'd2) $display("FAIL abort_pre got=%0d exp=2", count1); else pass_cnt++;
    do_load(4'd4);
    total_cnt++; if (count1 !== 4'd4 || busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL abort_load count=%0d busy=%b done=%b exp=4,0,0", count1, busy1, done1); else pass_cnt++;
    cyc();
    total_cnt++; if (count1 !== 4'd4 || done1 !== 1'b0) $display("FAIL abort_hold count=%0d done=%b exp=4,0", count1, done1); else pass_cnt++;
  endtask

  task automatic test_reset_midrun();
    do_load(4'd9);
    do_start();
    cyc(); cyc(); cyc();
    total_cnt++; if (count1 !== 4'd6) $display("FAIL midrun_pre got=%0d exp=6", count1); else pass_cnt++;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total_cnt++; if ({count1, busy1, paused1, done1} !== 7'd0) $display("FAIL midrun_reset got=%b exp=0", {count1, busy1, paused1, done1}); else pass_cnt++;
    do_start();
    total_cnt++; if (done1 !== 1'b1 || count1 !== 4'd0) $display("FAIL midrun_start done=%b count=%0d exp=1,0", done1, count1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_clamp_restart();
    test_auto_reload();
    test_pause();
    test_pause_on_tick();
    test_zero_and_abort();
    test_reset_midrun();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
